// File: rtl/decoder_if_pipe.sv
// RV32I instruction decoder for the IF/ID boundary. Decoded results are held in a
// 2-entry skid buffer so in_ready comes straight from a flop, never from out_ready.
module decoder_if_pipe #(
    parameter bit RV32E = 1'b0,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_ir,
    input  logic [31:0]      in_pc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_ir,
    output logic [31:0]      out_pc,
    output logic [10:0]      out_class,
    output logic [4:0]       out_instr_type,
    output logic [4:0]       out_rd,
    output logic [4:0]       out_rs1,
    output logic [4:0]       out_rs2,
    output logic             out_rf_we,
    output logic             out_illegal,
    output logic [CNT_W-1:0] dec_count
);

    typedef struct packed {
        logic [31:0] ir;
        logic [31:0] pc;
        logic [10:0] cls;
        logic [4:0]  typ;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        rf_we;
        logic        illegal;
    } entry_t;

    entry_t      dec;
    entry_t      m_entry;
    entry_t      s_entry;
    logic        m_valid;
    logic        s_valid;
    logic [4:0]  op;
    logic [10:0] cls;
    logic [4:0]  typ;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        illegal;
    logic        in_hs;
    logic        out_hs;

    // NOTE: every variable assigned here gets a default first, so no latch is inferred.
    always_comb begin
        op      = in_ir[6:2];
        cls     = '0;
        cls[0]  = (op == 5'b00101);
        cls[1]  = (op == 5'b01101);
        cls[2]  = (op == 5'b11000);
        cls[3]  = (op == 5'b11001);
        cls[4]  = (op == 5'b11011);
        cls[5]  = (op == 5'b00100);
        cls[6]  = (op == 5'b01100);
        cls[7]  = (op == 5'b00000);
        cls[8]  = (op == 5'b01000);
        cls[9]  = (op == 5'b00011);
        cls[10] = (op == 5'b11100);
        typ[0]  = cls[7] | cls[5] | cls[3] | cls[9] | cls[10];
        typ[1]  = cls[8];
        typ[2]  = cls[2];
        typ[3]  = cls[0] | cls[1];
        typ[4]  = cls[4];
        rd      = (typ[1] | typ[2]) ? 5'd0 : in_ir[11:7];
        rs1     = (typ[3] | typ[4]) ? 5'd0 : in_ir[19:15];
        rs2     = (typ[0] | typ[3] | typ[4]) ? 5'd0 : in_ir[24:20];
        illegal = (in_ir[1:0] != 2'b11) || (cls == '0)
                  || (RV32E && (rd[4] || rs1[4] || rs2[4]));

        dec         = '0;
        dec.ir      = in_ir;
        dec.pc      = in_pc;
        dec.illegal = illegal;
        if (!illegal) begin
            dec.cls   = cls;
            dec.typ   = typ;
            dec.rd    = rd;
            dec.rs1   = rs1;
            dec.rs2   = rs2;
            dec.rf_we = (rd != 5'd0);
        end
    end

    assign in_ready = !s_valid;
    assign in_hs    = in_valid && in_ready;
    assign out_hs   = m_valid && out_ready;

    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    // NOTE: payload registers are reset too, so out_* read as zero right after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_valid   <= 1'b0;
            s_valid   <= 1'b0;
            m_entry   <= '0;
            s_entry   <= '0;
            dec_count <= '0;
        end else begin
            if (out_hs) dec_count <= dec_count + CNT_W'(1);

            if (flush) begin
                m_valid <= 1'b0;
                s_valid <= 1'b0;
            end else if (out_hs && s_valid) begin
                m_entry <= s_entry;
                s_valid <= 1'b0;
            end else if (out_hs || !m_valid) begin
                m_valid <= in_hs;
                if (in_hs) m_entry <= dec;
            end else if (in_hs) begin
                // M is full and stalled; the skid entry absorbs this word.
                s_entry <= dec;
                s_valid <= 1'b1;
            end
        end
    end

    assign out_valid      = m_valid;
    assign out_ir         = m_entry.ir;
    assign out_pc         = m_entry.pc;
    assign out_class      = m_entry.cls;
    assign out_instr_type = m_entry.typ;
    assign out_rd         = m_entry.rd;
    assign out_rs1        = m_entry.rs1;
    assign out_rs2        = m_entry.rs2;
    assign out_rf_we      = m_entry.rf_we;
    assign out_illegal    = m_entry.illegal;

endmodule

// File: tb/tb_decoder_if_pipe.sv
// Self-checking bench for decoder_if_pipe: an RV32I instance and an RV32E/4-bit-counter
// instance share stimulus and are compared against a queue-based reference model.
module tb_decoder_if_pipe;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, out_ready;
    logic [31:0] in_ir, in_pc;

    logic        a_in_ready, a_out_valid, a_we, a_ill;
    logic [31:0] a_out_ir, a_out_pc, a_cnt;
    logic [10:0] a_class;
    logic [4:0]  a_type, a_rd, a_rs1, a_rs2;

    logic        b_in_ready, b_out_valid, b_we, b_ill;
    logic [31:0] b_out_ir, b_out_pc;
    logic [3:0]  b_cnt;
    logic [10:0] b_class;
    logic [4:0]  b_type, b_rd, b_rs1, b_rs2;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] ir;
        logic [31:0] pc;
    } item_t;

    item_t       q[$];
    int unsigned n_hs = 0;

    always #5 clk = ~clk;

    decoder_if_pipe #(.RV32E(1'b0), .CNT_W(32)) u_dut_a (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(a_in_ready), .in_ir(in_ir), .in_pc(in_pc),
        .out_valid(a_out_valid), .out_ready(out_ready), .out_ir(a_out_ir), .out_pc(a_out_pc),
        .out_class(a_class), .out_instr_type(a_type), .out_rd(a_rd), .out_rs1(a_rs1),
        .out_rs2(a_rs2), .out_rf_we(a_we), .out_illegal(a_ill), .dec_count(a_cnt)
    );

    decoder_if_pipe #(.RV32E(1'b1), .CNT_W(4)) u_dut_b (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(b_in_ready), .in_ir(in_ir), .in_pc(in_pc),
        .out_valid(b_out_valid), .out_ready(out_ready), .out_ir(b_out_ir), .out_pc(b_out_pc),
        .out_class(b_class), .out_instr_type(b_type), .out_rd(b_rd), .out_rs1(b_rs1),
        .out_rs2(b_rs2), .out_rf_we(b_we), .out_illegal(b_ill), .dec_count(b_cnt)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // Reference decode from the instruction-format rules:
    // returns {class, type, rd, rs1, rs2, rf_we, illegal}.
    function automatic logic [32:0] ref_dec(input logic [31:0] ir, input bit e);
        int          cb = -1;
        byte         fmt = "R";
        logic [10:0] c = '0;
        logic [4:0]  t = '0;
        logic [4:0]  rd, rs1, rs2;
        case (ir[6:2])
            5'b00101: begin cb = 0;  fmt = "U"; end
            5'b01101: begin cb = 1;  fmt = "U"; end
            5'b11000: begin cb = 2;  fmt = "B"; end
            5'b11001: begin cb = 3;  fmt = "I"; end
            5'b11011: begin cb = 4;  fmt = "J"; end
            5'b00100: begin cb = 5;  fmt = "I"; end
            5'b01100: begin cb = 6;  fmt = "R"; end
            5'b00000: begin cb = 7;  fmt = "I"; end
            5'b01000: begin cb = 8;  fmt = "S"; end
            5'b00011: begin cb = 9;  fmt = "I"; end
            5'b11100: begin cb = 10; fmt = "I"; end
            default:  cb = -1;
        endcase
        if (cb < 0 || ir[1:0] != 2'b11) return 33'd1;
        c[cb] = 1'b1;
        if (fmt == "I") t = 5'd1;
        if (fmt == "S") t = 5'd2;
        if (fmt == "B") t = 5'd4;
        if (fmt == "U") t = 5'd8;
        if (fmt == "J") t = 5'd16;
        rd  = (fmt == "S" || fmt == "B") ? 5'd0 : ir[11:7];
        rs1 = (fmt == "U" || fmt == "J") ? 5'd0 : ir[19:15];
        rs2 = (fmt == "R" || fmt == "S" || fmt == "B") ? ir[24:20] : 5'd0;
        if (e && (rd >= 16 || rs1 >= 16 || rs2 >= 16)) return 33'd1;
        return {c, t, rd, rs1, rs2, rd != 5'd0, 1'b0};
    endfunction

    task automatic check_state();
        check("a.in_ready", a_in_ready, q.size() < 2);
        check("b.in_ready", b_in_ready, q.size() < 2);
        check("a.out_valid", a_out_valid, q.size() != 0);
        check("b.out_valid", b_out_valid, q.size() != 0);
        check("a.dec_count", a_cnt, n_hs);
        check("b.dec_count", b_cnt, n_hs % 16);
        if (q.size() != 0) begin
            check("a.ir_pc", {a_out_ir, a_out_pc}, {q[0].ir, q[0].pc});
            check("b.ir_pc", {b_out_ir, b_out_pc}, {q[0].ir, q[0].pc});
            check("a.decode", {a_class, a_type, a_rd, a_rs1, a_rs2, a_we, a_ill}, ref_dec(q[0].ir, 1'b0));
            check("b.decode", {b_class, b_type, b_rd, b_rs1, b_rs2, b_we, b_ill}, ref_dec(q[0].ir, 1'b1));
        end
    endtask

    // Called at a falling edge: drive inputs, advance the model, check at the next falling edge.
    task automatic cycle(input bit v, input logic [31:0] ir, input logic [31:0] pc,
                         input bit rdy, input bit fl);
        bit hs_out, acc;
        in_valid  = v;
        in_ir     = ir;
        in_pc     = pc;
        out_ready = rdy;
        flush     = fl;
        hs_out = (q.size() != 0) && rdy;
        acc    = v && (q.size() < 2) && !fl;
        if (hs_out) n_hs++;
        if (fl) q.delete();
        else begin
            if (hs_out) void'(q.pop_front());
            if (acc) q.push_back('{ir: ir, pc: pc});
        end
        @(posedge clk);
        @(negedge clk);
        check_state();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        q.delete();
        n_hs = 0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    logic [31:0] stream [5] = '{32'h0080006F, 32'h00008067, 32'h00208463, 32'h0020A023, 32'h123450B7};
    logic [4:0]  stream_type [5] = '{5'b10000, 5'b00001, 5'b00100, 5'b00010, 5'b01000};
    logic [4:0]  legal_ops [11] = '{5'b00101, 5'b01101, 5'b11000, 5'b11001, 5'b11011, 5'b00100,
                                   5'b01100, 5'b00000, 5'b01000, 5'b00011, 5'b11100};

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_ir = '0; in_pc = '0;
        @(negedge clk);
        rst = 1'b0;
        check_state();
        check("a.reset_payload", {a_out_ir, a_out_pc, a_class, a_type, a_rd, a_rs1, a_rs2, a_we, a_ill}, '0);
        check("b.reset_payload", {b_out_ir, b_out_pc, b_class, b_type, b_ill}, '0);

        // addi x1,x0,5: visible one cycle after acceptance, counted on the following cycle
        cycle(1, 32'h00500093, 32'h100, 1, 0);
        check("addi.class", a_class, 11'h020);
        check("addi.type", a_type, 5'b00001);
        check("addi.regs", {a_rd, a_rs1, a_rs2, a_we}, {5'd1, 5'd0, 5'd0, 1'b1});
        cycle(0, 32'h0, 32'h0, 1, 0);
        check("addi.count", a_cnt, 32'd1);

        // back-to-back jal/jalr/beq/sw/lui at full throughput
        for (int i = 0; i < 5; i++) begin
            cycle(1, stream[i], 32'h200 + 32'(4 * i), 1, 0);
            check("stream.type", a_type, stream_type[i]);
        end
        cycle(0, 32'h0, 32'h0, 1, 0);

        // stall: two accepted, third held off, then all drain in order
        cycle(1, 32'h00100113, 32'h300, 0, 0);
        cycle(1, 32'h00200193, 32'h304, 0, 0);
        check("stall.in_ready", a_in_ready, 1'b0);
        cycle(1, 32'h00300213, 32'h308, 0, 0);
        check("stall.hold_pc", a_out_pc, 32'h300);
        cycle(1, 32'h00300213, 32'h308, 1, 0);
        cycle(1, 32'h00300213, 32'h308, 1, 0);
        check("stall.third_pc", a_out_pc, 32'h308);
        cycle(0, 32'h0, 32'h0, 1, 0);

        // RV32E range check and an undecodable word
        cycle(1, 32'h00208833, 32'h400, 1, 0);
        check("rv32e.illegal", {b_ill, b_class, a_ill}, {1'b1, 11'h000, 1'b0});
        cycle(1, 32'hFFFFFFFF, 32'h404, 1, 0);
        check("ones.illegal", {a_ill, b_ill, a_class}, {1'b1, 1'b1, 11'h000});
        cycle(0, 32'h0, 32'h0, 1, 0);

        // flush with a full buffer drops everything including the offered word
        cycle(1, 32'h00100093, 32'h500, 0, 0);
        cycle(1, 32'h00200093, 32'h504, 0, 0);
        cycle(1, 32'h00300093, 32'h508, 0, 1);
        check("flush.state", {a_out_valid, a_in_ready}, {1'b0, 1'b1});
        cycle(0, 32'h0, 32'h0, 1, 0);

        // counter wrap on the 4-bit instance
        do_reset();
        check_state();
        for (int i = 0; i < 16; i++) cycle(1, 32'h00000013, 32'(i * 4), 1, 0);
        cycle(0, 32'h0, 32'h0, 1, 0);
        check("wrap.count", {b_cnt, a_cnt}, {4'd0, 32'd16});

        // asynchronous reset during a stalled transfer
        cycle(1, 32'h00100093, 32'h600, 0, 0);
        cycle(1, 32'h00200093, 32'h604, 0, 0);
        rst = 1'b1;
        #1;
        check("async_rst.valid", {a_out_valid, b_out_valid, a_in_ready}, {1'b0, 1'b0, 1'b1});
        q.delete();
        n_hs = 0;
        @(negedge clk);
        rst = 1'b0;
        check_state();

        // randomized traffic, mostly legal opcodes
        for (int i = 0; i < 400; i++) begin
            logic [31:0] ir;
            ir = $urandom;
            if ($urandom_range(3) != 0) begin
                ir[1:0] = 2'b11;
                ir[6:2] = legal_ops[$urandom_range(10)];
            end
            cycle($urandom_range(3) != 0, ir, $urandom, $urandom_range(2) != 0,
                  $urandom_range(19) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
